decode_queue_ctrl: RTL and testbench

//  Instruction queue and handshake controller between fetch and decode.

---
 rtl/decode_queue_ctrl.sv | 93 +++++++++
 tb/tb_decode_queue_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_ctrl.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instr} with show-ahead
// head, valid/ready handshakes on both sides, flush, and a saturating stall counter.
module decode_queue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 12,
    parameter int INSTR_W = 32,
    parameter int STALL_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [PC_W-1:0]          fetch_pc,
    input  logic [INSTR_W-1:0]       fetch_instr,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [PC_W-1:0]          dec_pc,
    output logic [INSTR_W-1:0]       dec_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [STALL_W-1:0]       stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_W-1:0]    mem_pc_q    [DEPTH];
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];

    logic [AW-1:0]      head_q, head_d;
    logic [AW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               push, pop;

    always_comb begin
        full        = (count_q == FULL_CNT);
        empty       = (count_q == '0);
        fetch_ready = !full && !flush;
        dec_valid   = !empty && !flush;
        push        = fetch_valid && fetch_ready;
        pop         = dec_valid && dec_ready;
        dec_pc      = dec_valid ? mem_pc_q[head_q]    : '0;
        dec_instr   = dec_valid ? mem_instr_q[head_q] : '0;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (pop)  head_d = head_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end

        // Stall counter holds at all-ones rather than wrapping.
        stall_d = stall_q;
        if (dec_valid && !dec_ready && (stall_q != '1))
            stall_d = stall_q + STALL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // Storage is data-only; its contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[tail_q]    <= fetch_pc;
            mem_instr_q[tail_q] <= fetch_instr;
        end
    end

    assign count     = count_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Scoreboard bench for decode_queue_ctrl: queue-based reference model drives expectations,
// a negedge monitor compares status and head data; a STALL_W=2 copy checks saturation.
module tb_decode_queue_ctrl;
    localparam int DEPTH   = 4;
    localparam int PC_W    = 12;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               fetch_valid;
    logic [PC_W-1:0]    fetch_pc;
    logic [INSTR_W-1:0] fetch_instr;
    logic               dec_ready;

    logic               fetch_ready, dec_valid, full, empty;
    logic [PC_W-1:0]    dec_pc;
    logic [INSTR_W-1:0] dec_instr;
    logic [2:0]         count;
    logic [15:0]        stall_cnt;

    logic               s_fetch_ready, s_dec_valid, s_full, s_empty;
    logic [PC_W-1:0]    s_dec_pc;
    logic [INSTR_W-1:0] s_dec_instr;
    logic [2:0]         s_count;
    logic [1:0]         s_stall_cnt;

    decode_queue_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .STALL_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr),
        .count(count), .full(full), .empty(empty), .stall_cnt(stall_cnt)
    );

    decode_queue_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .STALL_W(2)) u_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(s_fetch_ready),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .dec_valid(s_dec_valid), .dec_ready(dec_ready),
        .dec_pc(s_dec_pc), .dec_instr(s_dec_instr),
        .count(s_count), .full(s_full), .empty(s_empty), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    typedef struct {
        bit fr;
        bit dv;
        int cnt;
        int stall;
    } cyc_t;

    ent_t model_q[$];
    ent_t sb_q[$];
    cyc_t exp_q[$];
    int   model_stall = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts what the DUT shows this cycle,
    // then advances to the state after the coming edge.
    task automatic cycle(input bit fv, input logic [PC_W-1:0] pc,
                         input logic [INSTR_W-1:0] ins, input bit dr, input bit fl);
        cyc_t c;
        ent_t e;
        bit   fr, dv;
        @(posedge clk);
        #1;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = ins;
        dec_ready   = dr;
        flush       = fl;
        fr = (model_q.size() < DEPTH) && !fl;
        dv = (model_q.size() > 0) && !fl;
        c.fr = fr;
        c.dv = dv;
        c.cnt = model_q.size();
        c.stall = model_stall;
        exp_q.push_back(c);
        if (fl) begin
            model_q.delete();
            sb_q.delete();
        end else begin
            if (dv && dr) void'(model_q.pop_front());
            if (fv && fr) begin
                e.pc = pc;
                e.instr = ins;
                model_q.push_back(e);
                sb_q.push_back(e);
            end
        end
        if (dv && !dr) model_stall++;
    endtask

    always @(negedge clk) begin
        cyc_t c;
        ent_t h;
        if (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            chk("fetch_ready", 64'(fetch_ready), 64'(c.fr));
            chk("dec_valid", 64'(dec_valid), 64'(c.dv));
            chk("count", 64'(count), 64'(c.cnt));
            chk("full", 64'(full), 64'(c.cnt == DEPTH));
            chk("empty", 64'(empty), 64'(c.cnt == 0));
            chk("stall_cnt", 64'(stall_cnt), 64'(c.stall));
            chk("stall_sat", 64'(s_stall_cnt), 64'((c.stall > 3) ? 3 : c.stall));
            chk("sat_count", 64'(s_count), 64'(c.cnt));
            if (!c.dv) begin
                chk("dec_pc_idle", 64'(dec_pc), 64'(0));
                chk("dec_instr_idle", 64'(dec_instr), 64'(0));
            end else if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: dec_valid=%0d with no expected entry", dec_valid);
            end else begin
                h = sb_q[0];
                chk("dec_pc", 64'(dec_pc), 64'(h.pc));
                chk("dec_instr", 64'(dec_instr), 64'(h.instr));
                if (dec_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic reset_midstream();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_dec_valid", 64'(dec_valid), 64'(0));
        chk("rst_fetch_ready", 64'(fetch_ready), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("rst_stall_sat", 64'(s_stall_cnt), 64'(0));
        fetch_valid = 1'b0;
        dec_ready   = 1'b0;
        flush       = 1'b0;
        model_q.delete();
        sb_q.delete();
        model_stall = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [PC_W-1:0] pc;
        rst = 1'b1;
        flush = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc = '0;
        fetch_instr = '0;
        dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // In-order delivery with decode always ready
        cycle(1, 12'h000, 32'h00500093, 1, 0);
        cycle(1, 12'h004, 32'h00A00113, 1, 0);
        cycle(1, 12'h008, 32'h002081B3, 1, 0);
        repeat (2) cycle(0, 12'h000, 32'h0, 1, 0);

        // Fill to full, reject a fifth, pop-only while full, then accept
        for (int i = 0; i < 4; i++) cycle(1, 12'(16 * i), 32'hA000_0000 + 32'(i), 0, 0);
        cycle(1, 12'h040, 32'hA000_0004, 0, 0);
        cycle(1, 12'h040, 32'hA000_0004, 1, 0);
        cycle(1, 12'h040, 32'hA000_0004, 0, 0);
        repeat (5) cycle(0, 12'h000, 32'h0, 1, 0);

        // Simultaneous push/pop across pointer wrap
        cycle(1, 12'h100, 32'hB000_0000, 1, 0);
        for (int i = 1; i <= 10; i++) cycle(1, 12'h100 + 12'(4 * i), 32'hB000_0000 + 32'(i), 1, 0);
        repeat (2) cycle(0, 12'h000, 32'h0, 1, 0);

        // Flush with push and pop requested together
        for (int i = 0; i < 3; i++) cycle(1, 12'h200 + 12'(4 * i), 32'hC000_0000 + 32'(i), 0, 0);
        cycle(1, 12'h20C, 32'hC000_0003, 1, 1);
        repeat (2) cycle(0, 12'h000, 32'h0, 1, 0);

        // Stall run long enough to saturate the 2-bit counter
        cycle(1, 12'h300, 32'hD000_0000, 0, 0);
        repeat (6) cycle(0, 12'h000, 32'h0, 0, 0);
        cycle(0, 12'h000, 32'h0, 1, 0);

        // Asynchronous reset with entries in flight, then normal restart
        cycle(1, 12'h400, 32'hE000_0000, 0, 0);
        cycle(1, 12'h404, 32'hE000_0001, 0, 0);
        cycle(0, 12'h000, 32'h0, 0, 0);
        reset_midstream();
        cycle(1, 12'h500, 32'hF000_0000, 0, 0);
        cycle(0, 12'h000, 32'h0, 1, 0);
        cycle(0, 12'h000, 32'h0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            pc = 12'($urandom);
            cycle(($urandom_range(0, 9) < 7), pc, $urandom,
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end
        cycle(0, 12'h000, 32'h0, 1, 0);

        @(negedge clk);
        #1;
        chk("exp_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
